// File: rtl/imem_loader.sv
// imem_loader: byte-stream boot loader for the instruction memory.
// Takes LEN (word count N), 4N little-endian payload bytes and an 8-bit
// additive checksum. Each payload word is written to the instruction memory
// one cycle after its fourth byte is accepted. The core is held in reset while
// a load is active.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           one-cycle pulse; starts a load (ignored while a load is active)
//   in_data/in_valid/in_ready  byte stream; a transfer is in_valid && in_ready
//   mem_we/mem_addr/mem_wdata  single-cycle word write port
//   cpu_hold        keeps the core in reset during a load or after a failed load
//   done/err        sticky load status
//   words_written   number of words written in the current load
module imem_loader #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_written
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [1:0]         idx_q, idx_d;
    logic [7:0]         sum_q, sum_d;
    logic [23:0]        asm_q, asm_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic               last_q, last_d;

    logic               xfer;
    logic               do_start;
    logic               csum_byte;

    assign xfer = in_valid && in_ready_q;

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        err_d       = err_q;
        words_d     = words_q;
        addr_d      = addr_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        asm_d       = asm_q;
        len_d       = len_q;
        last_d      = last_q;
        do_start    = 1'b0;
        csum_byte   = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) do_start = 1'b1;
            end
            S_LEN: begin
                if (xfer) begin
                    if (in_data == 8'd0 || 32'(in_data) > DEPTH) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        len_d   = CNT_W'(in_data);
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // Write cycle bookkeeping; the address stays on the last word
                if (mem_we_q) begin
                    words_d = words_q + CNT_W'(1);
                    if (!last_q) addr_d = addr_q + ADDR_W'(1);
                end
                if (xfer) begin
                    if (last_q) begin
                        // Payload complete: byte arriving during the final write is CSUM
                        csum_byte = 1'b1;
                    end else begin
                        sum_d = sum_q + in_data;
                        unique case (idx_q)
                            2'd0: asm_d[7:0]   = in_data;
                            2'd1: asm_d[15:8]  = in_data;
                            2'd2: asm_d[23:16] = in_data;
                            default: begin
                                mem_we_d    = 1'b1;
                                mem_addr_d  = addr_q;
                                mem_wdata_d = {in_data, asm_q};
                                if (CNT_W'(addr_q) + CNT_W'(1) == len_q) last_d = 1'b1;
                            end
                        endcase
                        idx_d = idx_q + 2'd1;
                    end
                end else if (last_q) begin
                    state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (xfer) csum_byte = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (csum_byte) begin
            if (in_data == sum_q) begin
                state_d    = S_DONE;
                done_d     = 1'b1;
                cpu_hold_d = 1'b0;
            end else begin
                state_d = S_ERR;
                err_d   = 1'b1;
            end
        end

        if (do_start) begin
            state_d    = S_LEN;
            cpu_hold_d = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b0;
            words_d    = '0;
            addr_d     = '0;
            idx_d      = '0;
            sum_d      = '0;
            last_d     = 1'b0;
        end

        in_ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            words_q     <= '0;
            addr_q      <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            asm_q       <= '0;
            len_q       <= '0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
            words_q     <= words_d;
            addr_q      <= addr_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            asm_q       <= asm_d;
            len_q       <= len_d;
            last_q      <= last_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign cpu_hold      = cpu_hold_q;
    assign done          = done_q;
    assign err           = err_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed images, expected writes queued by the
// stimulus and checked by a separate monitor on each mem_we.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [6:0]  words_written;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(6), .DEPTH(64)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err),
        .words_written(words_written)
    );

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks;
    int          errors;
    logic [31:0] img[64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write must match the oldest expected write
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && mem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                             mem_addr, mem_wdata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write_addr", 32'(mem_addr), 32'(e.addr));
                    chk("write_data", mem_wdata, e.data);
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge
    task automatic send_byte(input logic [7:0] b, input bit exp_we, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got in_ready 0 expected 1 within 64 cycles");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (exp_we) chk("we_latency", 32'(mem_we), 32'd1);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_hold", 32'(cpu_hold), 32'd1);
        chk("start_clear", {29'd0, done, err, in_ready}, 32'd1);
        chk("start_words", 32'(words_written), 32'd0);
    endtask

    task automatic load(input int n, input logic [7:0] csum, input int maxgap);
        logic [31:0] wv;
        send_byte(8'(n), 1'b0, $urandom_range(0, maxgap));
        for (int w = 0; w < n; w++) begin
            wv = img[w];
            for (int k = 0; k < 4; k++) begin
                if (k == 3) exp_q.push_back({6'(w), wv});
                send_byte(wv[8*k +: 8], k == 3, $urandom_range(0, maxgap));
            end
        end
        send_byte(csum, 1'b0, $urandom_range(0, maxgap));
    endtask

    task automatic chk_status(input string name, input logic exp_done, input logic exp_err,
                              input logic exp_hold, input int exp_words);
        chk({name, "_done"}, 32'(done), 32'(exp_done));
        chk({name, "_err"}, 32'(err), 32'(exp_err));
        chk({name, "_hold"}, 32'(cpu_hold), 32'(exp_hold));
        chk({name, "_words"}, 32'(words_written), 32'(exp_words));
        chk({name, "_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic nominal_image();
        img[0] = 32'h0010_8093;
        img[1] = 32'h0042_0213;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal;
    end

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        checks   = 0;
        errors   = 0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        chk_status("reset", 1'b0, 1'b0, 1'b0, 0);
        chk("reset_we", 32'(mem_we), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Nominal back-to-back load
        nominal_image();
        do_start();
        load(2, 8'h7A, 0);
        chk_status("nominal", 1'b1, 1'b0, 1'b0, 2);

        // Same image with random gaps between bytes
        do_start();
        load(2, 8'h7A, 3);
        chk_status("gaps", 1'b1, 1'b0, 1'b0, 2);

        // Bad lengths: zero, then one past DEPTH
        do_start();
        send_byte(8'h00, 1'b0, 0);
        chk_status("len0", 1'b0, 1'b1, 1'b1, 0);
        do_start();
        send_byte(8'h41, 1'b0, 0);
        chk_status("len65", 1'b0, 1'b1, 1'b1, 0);

        // Checksum mismatch, then a clean reload
        do_start();
        load(2, 8'h7B, 0);
        chk_status("bad_csum", 1'b0, 1'b1, 1'b1, 2);
        do_start();
        load(2, 8'h7A, 0);
        chk_status("reload", 1'b1, 1'b0, 1'b0, 2);

        // Full depth: word i holds i, checksum = sum(0..63) mod 256 = 0xE0
        for (int i = 0; i < 64; i++) img[i] = 32'(i);
        do_start();
        load(64, 8'hE0, 0);
        chk_status("full", 1'b1, 1'b0, 1'b0, 64);

        // Reset after five payload bytes
        nominal_image();
        do_start();
        send_byte(8'h02, 1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) exp_q.push_back({6'd0, img[0]});
            send_byte(img[0][8*k +: 8], k == 3, 0);
        end
        send_byte(8'h13, 1'b0, 0);
        rst = 1'b0;
        #1;
        chk_status("midreset", 1'b0, 1'b0, 1'b0, 0);
        chk("midreset_we", 32'(mem_we), 32'd0);
        chk("midreset_addr", 32'(mem_addr), 32'd0);
        chk("midreset_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_start();
        load(2, 8'h7A, 0);
        chk_status("after_reset", 1'b1, 1'b0, 1'b0, 2);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream boot loader that writes a program image into the instruction memory.
- Writing is the loader's job; the instruction memory itself only serves the core's fetch reads.
- Receives bytes over a valid/ready stream (UART receiver or debug bridge), packs them little-endian into 32-bit words and drives a single-port word write interface.
- Holds the core in reset (cpu_hold) while loading, then verifies an 8-bit checksum.

Parameters:
- ADDR_W, 6, word-address width of the instruction memory.
- DEPTH, 64, number of 32-bit words; the maximum legal image length.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load. Accepted in IDLE, DONE and ERR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle. A transfer occurs when in_valid && in_ready.
- mem_we  output  1  one-cycle word write strobe.
- mem_addr  output  ADDR_W  word address of the write.
- mem_wdata  output  32  word being written.
- cpu_hold  output  1  keeps the core in reset while a load is active.
- done  output  1  image loaded and checksum matched; sticky.
- err  output  1  length or checksum error; sticky.
- words_written  output  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset (rst=0, async):
  - State = IDLE.
  - All outputs = 0; mem_wdata = 0; internal byte index, address and checksum = 0.
  - A reset mid-load abandons the load. Words already written stay in memory.
- Stream format: LEN byte N, then 4N payload bytes, then a CSUM byte.
  - Payload is little-endian: byte k of a word goes to bits [8k+7:8k].
  - CSUM = sum of all 4N payload bytes mod 256. LEN is not included.
- States:
  - IDLE:
    - in_ready=0, cpu_hold=0.
    - start -> LEN; cpu_hold=1; clears done, err, words_written, address, byte index and checksum.
  - LEN:
    - in_ready=1.
    - On transfer: N=0 or N>DEPTH -> ERR; otherwise latch N -> DATA.
  - DATA:
    - in_ready=1.
    - Each transfer places the byte in the assembly register and adds it to the checksum (8-bit wrap). The byte index advances 0..3.
    - On the 4th byte of a word, the next cycle has:
      - mem_we=1 for exactly one cycle;
      - mem_addr = current address;
      - mem_wdata = the full assembled word.
    - In that same write cycle the address and words_written increment, and in_ready=1 continues (no stall, back-to-back words allowed).
    - After the write of word N-1 -> CSUM. Address never exceeds DEPTH-1, so it never wraps.
  - CSUM:
    - in_ready=1.
    - On transfer: match -> DONE; mismatch -> ERR.
  - DONE:
    - in_ready=0, cpu_hold=0, done=1.
  - ERR:
    - in_ready=0, cpu_hold=1 (core stays held on a bad image), err=1.
- Start handling:
  - start in LEN, DATA or CSUM is ignored.
  - start in DONE or ERR restarts exactly as from IDLE.
- in_valid without in_ready: the byte is not consumed; no state change.
- mem_we is never asserted outside DATA; at most one write per 4 transfers.
- Latency:
  - Last payload byte transfer at cycle t -> mem_we at t+1.
  - CSUM transfer at cycle t -> done or err high at t+1.

Test Plan:
- Nominal load:
  - Stimulus: start, then 02, 93 80 10 00, 13 02 42 00, CSUM 0x7A.
  - Response: writes (0, 0x00108093) and (1, 0x00420213); done=1, err=0, words_written=2, cpu_hold falls after CSUM.
- Back-pressure gaps:
  - Stimulus: same image with in_valid low for 0-3 random cycles between bytes.
  - Response: identical writes and timing relative to the transfers; no extra mem_we.
- Bad length:
  - Stimulus: LEN=0x00, then a restart with LEN=0x41.
  - Response: err=1, no mem_we, cpu_hold stays 1 in both cases.
- Checksum mismatch:
  - Stimulus: nominal image with CSUM 0x7B.
  - Response: both words written, err=1, done=0, cpu_hold=1.
  - A subsequent start plus the correct image gives done=1.
- Full depth:
  - Stimulus: LEN=64 with the payload word value = its index.
  - Response: 64 writes at addresses 0..63, last one (63, 0x0000003F); words_written=64; done=1.
- Reset mid-load:
  - Stimulus: assert rst after 5 payload bytes.
  - Response: all outputs 0 immediately (async); the next start performs a clean load from address 0.
